// File: rtl/expr_share_pkg.sv
// Shared constants for the expression-datapath scheduler.
// Holds the operand/result widths, the bit layout of the operand bundle
// (a0 at the MSB end, b5 at the LSB end) and the scheduler state type.
package expr_share_pkg;

  localparam int OPND_W = 60;
  localparam int RES_W  = 90;

  // Operand bundle field layout: {a0,a1,a2,a3,a4,a5,b0,b1,b2,b3,b4,b5}
  localparam int A0_OFF = 56;  localparam int A0_W = 4;
  localparam int A1_OFF = 51;  localparam int A1_W = 5;
  localparam int A2_OFF = 45;  localparam int A2_W = 6;
  localparam int A3_OFF = 41;  localparam int A3_W = 4;
  localparam int A4_OFF = 36;  localparam int A4_W = 5;
  localparam int A5_OFF = 30;  localparam int A5_W = 6;
  localparam int B0_OFF = 26;  localparam int B0_W = 4;
  localparam int B1_OFF = 21;  localparam int B1_W = 5;
  localparam int B2_OFF = 15;  localparam int B2_W = 6;
  localparam int B3_OFF = 11;  localparam int B3_W = 4;
  localparam int B4_OFF = 6;   localparam int B4_W = 5;
  localparam int B5_OFF = 0;   localparam int B5_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/expr_share_sched_rr_pick.sv
// Round-robin picker: scans req_valid circularly starting at rr_ptr and
// returns the first requester found.
//   req_valid  in   per-requester request vector
//   rr_ptr     in   index where the scan starts
//   grant      out  one-hot winner (0 when nothing requests)
//   grant_idx  out  binary winner index (0 when nothing requests)
//   any_valid  out  at least one request present
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_valid
);

  int idx;

  always_comb begin
    grant_idx = '0;
    idx       = 0;
    any_valid = |req_valid;
    // Walk from the farthest position back to rr_ptr so that the closest
    // set bit (in circular order) is the last assignment and wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[IDW'(idx)]) grant_idx = IDW'(idx);
    end
    grant = any_valid ? (NREQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/expr_share_sched.sv
// Time-multiplexes one shared expression datapath between NREQ requesters.
// A round-robin winner's operand bundle is launched on ex_opnd, the result
// ex_y is captured EXEC_LAT edges later and returned on a valid/ready
// response channel tagged with the requester id.
//   clk, rst    clock and asynchronous active-high reset
//   req_valid   per-requester request
//   req_ready   one-hot accept, combinational, only while idle
//   req_data    operand bundles, requester i at [i*OPND_W +: OPND_W]
//   ex_opnd     operands presented to the shared datapath
//   ex_y        datapath result
//   rsp_valid / rsp_ready / rsp_id / rsp_data   response channel
//   busy        scheduler not idle
//
// state | meaning
// IDLE  | waiting for a request; grant offered combinationally
// WAIT  | operands launched, counting down EXEC_LAT edges
// RESP  | result held on the response channel until accepted
module expr_share_sched
  import expr_share_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int EXEC_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*OPND_W-1:0]   req_data,
  output logic [OPND_W-1:0]        ex_opnd,
  input  logic [RES_W-1:0]         ex_y,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [RES_W-1:0]         rsp_data,
  output logic                     busy
);

  localparam int IDW   = $clog2(NREQ);
  localparam int CNT_W = $clog2(EXEC_LAT + 1);

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_valid;
  logic [IDW-1:0]     ptr_next;
  logic [OPND_W-1:0]  opnd_sel;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  always_comb begin
    opnd_sel = req_data[int'(grant_idx)*OPND_W +: OPND_W];
    ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    // Gated by rst so no grant is ever advertised while held in reset.
    req_ready = (state == IDLE && !rst) ? grant : '0;
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      ex_opnd   <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            ex_opnd <= opnd_sel;
            rsp_id  <= grant_idx;
            rr_ptr  <= ptr_next;
            cnt     <= CNT_W'(EXEC_LAT);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            rsp_data  <= ex_y;
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/expr_share_sched.md
Name: expr_share_sched

Overview:
- Time-multiplexes one combinational expression datapath between NREQ requesters.
- The datapath has operand bundle a0..a5/b0..b5 (60 bits) and a 90-bit result y.
- Round-robin arbitration picks a requester. The block registers the winner's operands, waits EXEC_LAT cycles, captures y and returns it on a valid/ready response channel tagged with the requester id.
- Sits between regression stimulus sources and a shared expression_* instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- EXEC_LAT, 1, cycles from operand launch to result sample (>=1; covers datapath depth plus optional retiming).
- OPND_W, 60, operand bundle width; fixed by package constant.
- RES_W, 90, result width; fixed by package constant.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot grant/accept.
- req_data  in  NREQ*OPND_W  operand bundles; requester i at [i*OPND_W +: OPND_W].
- ex_opnd  out  OPND_W  operands to shared datapath.
- ex_y  in  RES_W  datapath result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts.
- rsp_id  out  $clog2(NREQ)  requester that owns rsp_data.
- rsp_data  out  RES_W  captured result.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state=IDLE, rr_ptr=0, wait counter=0, ex_opnd=0, rsp_data=0, rsp_id=0, rsp_valid=0, req_ready=0, busy=0.
- Reset takes effect immediately, mid-operation included. Any in-flight operation is dropped, with no response.
- Operand bundle packing, MSB first: {a0[3:0],a1[4:0],a2[5:0],a3[3:0],a4[4:0],a5[5:0],b0,b1,b2,b3,b4,b5}. a0 occupies [59:56] and b5 occupies [5:0]. The bundle is passed opaquely, with no sign handling.
- IDLE:
  - If any req_valid, grant g = first set bit scanning circularly from rr_ptr.
  - req_ready[g]=1 combinationally in that cycle only; all other bits are 0.
  - req_ready is 0 in every other state.
  - At the edge: ex_opnd<=req_data[g], rsp_id<=g, rr_ptr<=(g+1) mod NREQ, cnt<=EXEC_LAT, go WAIT.
  - req_valid dropped before a grant has no effect; no state is kept.
- WAIT:
  - ex_opnd is held stable; cnt decrements each edge.
  - At the edge where cnt==1: rsp_data<=ex_y, rsp_valid<=1, go RESP.
  - Result is therefore sampled EXEC_LAT edges after the accept edge.
  - ex_y values before that edge are ignored.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id stay stable until rsp_valid && rsp_ready.
  - On handshake: rsp_valid<=0, go IDLE.
  - No new request is accepted in the handshake cycle.
  - Throughput: one operation per EXEC_LAT+2 cycles minimum.
- ex_opnd keeps its last value in IDLE (no toggle). It changes only at an accept edge.
- Fairness: a continuously requesting requester is served within NREQ grants.
- Simultaneous requests: the round-robin pointer alone decides; fixed priority is never used.
- rr_ptr wraps NREQ-1 -> 0.

Decomposition:
- Package expr_share_pkg holds:
  - OPND_W=60 and RES_W=90;
  - per-field offset/width localparams for a0..b5;
  - the state enum {IDLE, WAIT, RESP}.
- Sub-module rr_pick (combinational): inputs req_valid and rr_ptr; outputs one-hot grant, binary index and any_valid.
- The pointer register stays in expr_share_sched.

Test Plan:
1. Reset, EXEC_LAT=1. Stimulus: req_valid=4'b0001, req_data[0]=60'h_A1F_3C8_5E2_7B4_D6, ex_y model = f(ex_opnd). Response: req_ready=4'b0001 in the request cycle; ex_opnd equals the bundle after the edge; rsp_valid high one edge later; rsp_id=0; rsp_data=f(bundle).
2. req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0; each accept is spaced exactly 3 cycles apart.
3. rr_ptr=1, req_valid=4'b0101 -> req_ready=4'b0100, rsp_id=2; the next grant goes to req0.
4. rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay stable; req_ready=0 throughout; busy=1.
5. EXEC_LAT=3, ex_y driven 90'h1 for two cycles then 90'h2A -> rsp_data=90'h2A, sampled on the third edge after accept.
6. Assert rst during WAIT (between clock edges) -> rsp_valid=0, busy=0, ex_opnd=0 immediately. After release, req0 wins a 4'b1111 contention.
